multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences a multi-cycle version of the CPU datapath.
- Each instruction is split into fetch, decode, execute, memory and writeback steps, one per clock.
- Memory steps stall on a ready handshake from the shared instruction/data memory.
- Replaces the combinational ControlUnit when the datapath is shared across cycles; sits beside Datapath inside CPU.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory state waits for MemReady before a bus error. Legal range 1..15; counter is 4 bits.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high
- opcode  input  4  instruction opcode from the instruction register
- Zero  input  1  ALU zero flag (BEQ/BNE only)
- MemReady  input  1  memory completes the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load gated by the branch condition in the datapath
- BranchNe  output  1  1 = branch on !Zero, 0 = branch on Zero
- PCSrc  output  2  00 ALU result, 01 ALUOut register, 10 jump target
- IorD  output  1  memory address select: 0 PC, 1 ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- RegDst  output  1  1 = rd, 0 = rt
- MemToReg  output  1  writeback from MDR
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 PC, 1 regA
- ALUSrcB  output  2  00 regB, 01 const 1, 10 sign-extended imm
- ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
- Halted  output  1  FSM is in HALT
- BusError  output  1  sticky; set on memory timeout
- IllegalOp  output  1  one-cycle pulse on an undefined opcode
- State  output  4  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, HALT=11. Codes 12-15 return to FETCH.
- Opcode map: 0000 R-type, 0100 ADDI, 1011 LW, 1111 SW, 0010 BEQ, 0011 BNE, 1000 JMP, 0001 HALT; all others are illegal.
- Reset, applied at any state including mid-memory-wait:
  - next state FETCH, wait counter 0, BusError 0.
  - All outputs are 0 in the reset cycle.
- Defaults: every control output is 0 unless listed for the state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=MemReady (Mealy).
  - Stays in FETCH until MemReady, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - R-type -> EXEC_R; ADDI -> EXEC_I; LW/SW -> MEM_ADDR
  - BEQ/BNE -> BRANCH; JMP -> JUMP; HALT -> HALT
  - illegal -> FETCH with IllegalOp=1 for that cycle (instruction treated as NOP).
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next WB_ALU, with RegDst=1 latched into the writeback.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next WB_ALU with RegDst=0.
  - WB_ALU therefore drives RegDst from a 1-bit register captured in EXEC_R/EXEC_I.
- WB_ALU: RegWrite=1, MemToReg=0. Next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1; on MemReady -> WB_MEM.
- MEM_WR: MemWrite=1, IorD=1; on MemReady -> FETCH.
- WB_MEM: RegWrite=1, MemToReg=1, RegDst=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01, BranchNe=(opcode==0011). Next FETCH.
- JUMP: PCWrite=1, PCSrc=10. Next FETCH.
- HALT: Halted=1, all other controls 0. Only Reset exits.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR, and whenever MemReady=1.
  - Increments each cycle that a memory state sees MemReady=0.
  - When the counter reaches MEM_TIMEOUT with MemReady still 0: next state HALT and BusError set; no PC, IR or register write occurs.
- MemReady asserted in the same cycle as the timeout is accepted: the normal transition wins.
- opcode is sampled only in DECODE, EXEC_R/EXEC_I (for the RegDst latch) and BRANCH. Changes in other states have no effect.
- Latency, assuming MemReady=1 immediately:
  - R/ADDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/BNE/JMP: 3 cycles
  - illegal: 2 cycles
  - each cycle of MemReady=0 adds one cycle.

Test Plan:
- Reset, then opcode=0000, MemReady=1 -> State sequence 0,1,2,7,0. IRWrite/PCWrite high in the FETCH cycle only; RegWrite=1 and RegDst=1 in cycle 4.
- LW (1011), MemReady held low 2 cycles in MEM_RD -> State 0,1,4,5,5,5,8,0. MemRead=1 and IorD=1 for all three MEM_RD cycles; MemToReg=1 in WB_MEM.
- SW (1111), MemReady never asserted, MEM_TIMEOUT=3 -> MEM_WR held for 3 cycles, then State=11, BusError=1, Halted=1. RegWrite and PCWrite stay 0 throughout.
- BNE (0011) -> BRANCH cycle shows PCWriteCond=1, BranchNe=1, PCSrc=01, ALUOp=01; the next state is FETCH regardless of Zero.
- opcode=0111 -> IllegalOp pulses for exactly one cycle in DECODE; the next state is FETCH with no RegWrite/MemWrite.
- HALT (0001) -> State=11 persists for 20 cycles with MemReady toggling. Reset during MEM_RD with MemReady=0 -> next cycle State=0, BusError=0, counter cleared.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Sequencing FSM for the multi-cycle CPU datapath. Each instruction runs as
//   fetch / decode / execute / memory / writeback steps, one step per clock.
//   Memory steps (FETCH, MEM_RD, MEM_WR) stall until MemReady. A stall that
//   lasts MEM_TIMEOUT cycles is treated as a bus error: the FSM parks in HALT
//   with BusError set.
//
// Parameters
//   MEM_TIMEOUT  cycles a memory step may wait before a bus error (1..15)
//
// Ports
//   Clock, Reset     rising-edge clock, synchronous active-high reset
//   opcode           instruction opcode from the instruction register
//   Zero             ALU zero flag (the branch decision is made in the datapath)
//   MemReady         memory completes the current access this cycle
//   PCWrite, PCWriteCond, BranchNe, PCSrc     PC update controls
//   IorD, MemRead, MemWrite, IRWrite          memory / IR controls
//   RegDst, MemToReg, RegWrite                register file controls
//   ALUSrcA, ALUSrcB, ALUOp                   ALU operand / operation select
//   Halted, BusError, IllegalOp, State        status and debug
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Halted,
  output logic       BusError,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1111;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_BNE  = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b0001;

  // Timeout fires on the cycle whose increment would reach MEM_TIMEOUT.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       regdst_q, regdst_d;
  logic       is_sw_q, is_sw_d;
  logic       mem_step;

  // The branch decision is taken in the datapath; the FSM never looks at Zero.
  logic       zero_unused;
  assign zero_unused = Zero;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bus_err_d   = bus_err_q;
    regdst_d    = regdst_q;
    is_sw_d     = is_sw_q;
    mem_step    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    Halted      = 1'b0;
    IllegalOp   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_step = 1'b1;
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        // PC+1 and IR load commit only in the cycle the fetch completes.
        IRWrite  = MemReady;
        PCWrite  = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        // LW/SW split is remembered here so MEM_ADDR does not depend on opcode.
        is_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_R:           state_d = S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_JMP:         state_d = S_JUMP;
          OP_HALT:        state_d = S_HALT;
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b10;
        regdst_d = 1'b1;
        state_d  = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        regdst_d = 1'b0;
        state_d  = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        RegDst   = regdst_q;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_step = 1'b1;
        MemRead  = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_step = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        BranchNe    = (opcode == OP_BNE);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        state_d = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Wait counter: runs only while a memory step is stalled. Leaving a memory
    // step zeroes it, so every memory step is entered with a clean count.
    if (mem_step) begin
      if (MemReady) begin
        wait_d = 4'd0;
      end else if (wait_q >= WAIT_LAST) begin
        wait_d    = 4'd0;
        bus_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_d = wait_q + 4'd1;
      end
    end else begin
      wait_d = 4'd0;
    end

    // Everything reads as zero while Reset is held, whatever the current state.
    if (Reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      PCSrc       = 2'b00;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemToReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      Halted      = 1'b0;
      IllegalOp   = 1'b0;
    end
  end

  assign BusError = bus_err_q & ~Reset;
  assign State    = Reset ? 4'd0 : state_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 4'd0;
      bus_err_q <= 1'b0;
      regdst_q  <= 1'b0;
      is_sw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      regdst_q  <= regdst_d;
      is_sw_q   <= is_sw_d;
    end
  end

endmodule
